demultiplexador1x4_registrado: RTL and testbench

Write-side counterpart of the 4-input 16-bit selector. It takes one 16-bit source word and routes it, by 2-bit select M, into one of four registered output channels. Each channel carries a valid/accept handshake so a consumer can take the word at its own pace. The block sits between the result bus and four destination units (registers / functional units). It stalls the source while the addressed channel still holds an unconsumed word.

---
 rtl/demultiplexador1x4_registrado.sv | 74 +++++++
 tb/tb_demultiplexador1x4_registrado.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/demultiplexador1x4_registrado.sv
`default_nettype none
// ============================================================================
// Module   : demultiplexador1x4_registrado
// Purpose  : Routes one source word to one of four registered channels, each
//            with a valid/accept handshake, and counts accepted words.
// Revision : 1.0 - initial release
// ============================================================================
module demultiplexador1x4_registrado #(
  parameter int LARGURA      = 16,
  parameter int LARGURA_CONT = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [LARGURA-1:0]      entrada,
  input  logic [1:0]              M,
  input  logic                    valido_entrada,
  output logic                    pronto_entrada,
  output logic [LARGURA-1:0]      saida0,
  output logic [LARGURA-1:0]      saida1,
  output logic [LARGURA-1:0]      saida2,
  output logic [LARGURA-1:0]      saida3,
  output logic [3:0]              valido,
  input  logic [3:0]              aceito,
  output logic [LARGURA_CONT-1:0] contador
);

  localparam logic [LARGURA_CONT-1:0] c_um = LARGURA_CONT'(1);

  logic [LARGURA-1:0]      r_saida [4];
  logic [3:0]              r_valido;
  logic [LARGURA_CONT-1:0] r_contador;
  logic                    w_transfer;
  logic [3:0]              w_escreve;

  // A held word may be replaced in the same cycle its consumer takes it.
  assign pronto_entrada = !r_valido[M] || aceito[M];
  assign w_transfer     = valido_entrada && pronto_entrada;

  genvar i;
  generate
    for (i = 0; i < 4; i++) begin : g_canal
      assign w_escreve[i] = w_transfer && (M == 2'(i));

      always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
          r_saida[i]  <= '0;
          r_valido[i] <= 1'b0;
        end else if (w_escreve[i]) begin
          r_saida[i]  <= entrada;
          r_valido[i] <= 1'b1;
        end else if (r_valido[i] && aceito[i]) begin
          r_valido[i] <= 1'b0;
        end
      end
    end
  endgenerate

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_contador <= '0;
    end else if (w_transfer) begin
      r_contador <= r_contador + c_um;
    end
  end

  assign saida0   = r_saida[0];
  assign saida1   = r_saida[1];
  assign saida2   = r_saida[2];
  assign saida3   = r_saida[3];
  assign valido   = r_valido;
  assign contador = r_contador;

endmodule
`default_nettype wire

// File: tb/tb_demultiplexador1x4_registrado.sv
`default_nettype none
// ============================================================================
// Module   : tb_demultiplexador1x4_registrado
// Purpose  : Directed and randomized checks of the 1x4 registered demux
//            against a channel-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_demultiplexador1x4_registrado;

  logic        clk;
  logic        rst;
  logic [15:0] entrada;
  logic [1:0]  M;
  logic        valido_entrada;
  logic        pronto_entrada;
  logic        pronto_w;
  logic [15:0] saida0, saida1, saida2, saida3;
  logic [15:0] w0, w1, w2, w3;
  logic [3:0]  valido;
  logic [3:0]  valido_w;
  logic [3:0]  aceito;
  logic [15:0] contador;
  logic [3:0]  contador_w;

  int checks   = 0;
  int failures = 0;

  logic [15:0] exp_s [4];
  bit          exp_v [4];
  int unsigned exp_c;

  demultiplexador1x4_registrado #(.LARGURA(16), .LARGURA_CONT(16)) dut (
    .clock(clk), .reset(rst), .entrada(entrada), .M(M),
    .valido_entrada(valido_entrada), .pronto_entrada(pronto_entrada),
    .saida0(saida0), .saida1(saida1), .saida2(saida2), .saida3(saida3),
    .valido(valido), .aceito(aceito), .contador(contador)
  );

  // Narrow counter instance so wrap-around is reached quickly.
  demultiplexador1x4_registrado #(.LARGURA(16), .LARGURA_CONT(4)) dut_w (
    .clock(clk), .reset(rst), .entrada(entrada), .M(M),
    .valido_entrada(valido_entrada), .pronto_entrada(pronto_w),
    .saida0(w0), .saida1(w1), .saida2(w2), .saida3(w3),
    .valido(valido_w), .aceito(aceito), .contador(contador_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [3:0] exp_valido();
    return {exp_v[3], exp_v[2], exp_v[1], exp_v[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      exp_s[k] = 16'h0000;
      exp_v[k] = 1'b0;
    end
    exp_c = 0;
  endtask

  task automatic check_state();
    chk("saida0", 32'(saida0), 32'(exp_s[0]));
    chk("saida1", 32'(saida1), 32'(exp_s[1]));
    chk("saida2", 32'(saida2), 32'(exp_s[2]));
    chk("saida3", 32'(saida3), 32'(exp_s[3]));
    chk("valido", 32'(valido), 32'(exp_valido()));
    chk("contador", 32'(contador), exp_c % 65536);
    chk("contador_w4", 32'(contador_w), exp_c % 16);
  endtask

  // One clock of stimulus: drive, check readiness, clock, update model, check.
  task automatic step(input logic [15:0] d, input logic [1:0] m, input logic vin,
                      input logic [3:0] ac);
    logic p;
    entrada        = d;
    M              = m;
    valido_entrada = vin;
    aceito         = ac;
    #1;
    if (!$isunknown(m)) begin
      p = !exp_v[m] || ac[m];
      chk("pronto_entrada", 32'(pronto_entrada), 32'(p));
    end else begin
      p = 1'b0;
    end
    @(posedge clk);
    for (int k = 0; k < 4; k++) begin
      if (vin && p && (int'(m) == k)) begin
        exp_s[k] = d;
        exp_v[k] = 1'b1;
      end else if (exp_v[k] && ac[k]) begin
        exp_v[k] = 1'b0;
      end
    end
    if (vin && p) exp_c = exp_c + 1;
    #1;
    check_state();
  endtask

  initial begin
    rst            = 1'b1;
    entrada        = '0;
    M              = '0;
    valido_entrada = 1'b0;
    aceito         = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b0;
    check_state();

    // Idle after reset
    step(16'h0000, 2'd0, 1'b0, 4'b0000);

    // Fill all four channels
    step(16'h0001, 2'd0, 1'b1, 4'b0000);
    step(16'h0002, 2'd1, 1'b1, 4'b0000);
    step(16'h0003, 2'd2, 1'b1, 4'b0000);
    step(16'h0004, 2'd3, 1'b1, 4'b0000);
    chk("fill_valido", 32'(valido), 32'h0000000f);
    chk("fill_contador", 32'(contador), 32'd4);

    // Stall on channel 2, then release it
    for (int k = 0; k < 3; k++) step(16'h0BEE, 2'd2, 1'b1, 4'b0000);
    chk("stall_saida2", 32'(saida2), 32'h3);
    step(16'h0BEE, 2'd2, 1'b1, 4'b0100);
    chk("release_saida2", 32'(saida2), 32'h0BEE);
    chk("release_contador", 32'(contador), 32'd5);

    // Streaming into channel 1 with continuous accept
    for (int k = 0; k < 8; k++) begin
      step(16'hA000 + 16'(k), 2'd1, 1'b1, 4'b0010);
      chk("stream_saida1", 32'(saida1), 32'hA000 + k);
    end
    chk("stream_contador", 32'(contador), 32'd13);

    // Drain everything; then accept on empty channels is ignored
    step(16'h0000, 2'd0, 1'b0, 4'b1111);
    step(16'h0000, 2'd0, 1'b0, 4'b1111);
    chk("empty_valido", 32'(valido), 32'h0);

    // Reload all, then consume channel 3 only
    for (int k = 0; k < 4; k++) step(16'h5000 + 16'(k), 2'(k), 1'b1, 4'b0000);
    step(16'h0000, 2'd0, 1'b0, 4'b1000);
    chk("consume3_valido", 32'(valido), 32'h7);
    chk("consume3_saida3", 32'(saida3), 32'h5003);

    // Unknown select with no source word has no effect
    step(16'hDEAD, 2'bxx, 1'b0, 4'b0000);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      step(16'($urandom), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) != 0),
           4'($urandom));
    end

    // Asynchronous reset between edges while streaming
    step(16'h1234, 2'd0, 1'b1, 4'b0001);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_state();
    #1;
    rst = 1'b0;

    // Sixteen transfers wrap the narrow counter back to zero
    for (int k = 0; k < 16; k++) step(16'(k), 2'd0, 1'b1, 4'b0001);
    chk("wrap_contador_w4", 32'(contador_w), 32'd0);
    chk("wrap_contador", 32'(contador), 32'd16);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
